// File: rtl/snn_sched_pkg.sv
// rtl/snn_sched_pkg.sv - shared types and constants for the SNN frame scheduler
package snn_sched_pkg;

    localparam int FRAME_W = 8;
    localparam int CNT_W   = 8;
    localparam int OUT_W   = 2;
    localparam int LVL_W   = 5;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ISSUE       = 2'd1,
        SETTLE_WAIT = 2'd2,
        SAMPLE      = 2'd3
    } sched_state_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

endpackage

// File: rtl/snn_frame_fifo.sv
// rtl/snn_frame_fifo.sv - input spike frame FIFO with push/pop and occupancy level
module snn_frame_fifo
    import snn_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  logic [FRAME_W-1:0] wdata_i,
    input  logic               pop_i,
    output logic [FRAME_W-1:0] rdata_o,
    output logic [LVL_W-1:0]   level_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [FRAME_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               do_push, do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Guard the requests so a full FIFO never overwrites and an empty one never underflows
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Frame storage; contents are don't-care while the slot is not occupied
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/snn_frame_scheduler.sv
// rtl/snn_frame_scheduler.sv - tick-paced frame issue to an SNN core (optional stats: SNN_SCHED_STATS_EN)
module snn_frame_scheduler
    import snn_sched_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic               system_clock,
    input  logic               reset,
    input  logic               frame_valid,
    input  logic [FRAME_W-1:0] frame_data,
    output logic               frame_ready,
    input  logic               tick,
    input  logic               run_en,
    output logic               snn_enable,
    output logic [FRAME_W-1:0] snn_input_spikes,
    input  logic [OUT_W-1:0]   snn_output_spikes,
    output logic               busy,
    output logic [LVL_W-1:0]   fifo_level,
    output logic [15:0]        spike_count,
    output logic [CNT_W-1:0]   underrun_count,
    output logic [CNT_W-1:0]   overrun_count
);

    sched_state_e       state_q, state_d;
    logic [3:0]         settle_q, settle_d;
    logic [FRAME_W-1:0] spikes_q, spikes_d;
    logic               pop;
    logic               fifo_full, fifo_empty;
    logic [FRAME_W-1:0] fifo_head;

    snn_frame_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (system_clock),
        .rst_ni  (reset),
        .push_i  (frame_valid),
        .wdata_i (frame_data),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign frame_ready      = !fifo_full;
    assign snn_enable       = (state_q == ISSUE);
    assign busy             = (state_q != IDLE);
    assign snn_input_spikes = spikes_q;

    // Next-state logic; the pop happens on the IDLE->ISSUE transition so the frame is on the bus during ISSUE
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick && run_en && !fifo_empty) begin
                    state_d = ISSUE;
                    pop     = 1'b1;
                end
            end
            ISSUE: begin
                state_d  = SETTLE_WAIT;
                settle_d = 4'(SETTLE - 1);
            end
            SETTLE_WAIT: begin
                if (settle_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            SAMPLE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        spikes_d = pop ? fifo_head : spikes_q;
    end

    // FSM, settle counter and presented-frame registers
    always_ff @(posedge system_clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            settle_q <= '0;
            spikes_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            spikes_q <= spikes_d;
        end
    end

`ifdef SNN_SCHED_STATS_EN
    logic [CNT_W-1:0] count0_q, count1_q, under_q, over_q;
    logic             sample_ev, underrun_ev, overrun_ev;

    // A tick with run_en cleared touches nothing, so both tick events require run_en
    assign sample_ev   = (state_q == SAMPLE);
    assign underrun_ev = tick && run_en && (state_q == IDLE) && fifo_empty;
    assign overrun_ev  = tick && run_en && (state_q != IDLE);

    // Saturating statistics counters
    always_ff @(posedge system_clock or negedge reset) begin
        if (!reset) begin
            count0_q <= '0;
            count1_q <= '0;
            under_q  <= '0;
            over_q   <= '0;
        end else begin
            count0_q <= sat_inc(count0_q, sample_ev && snn_output_spikes[0]);
            count1_q <= sat_inc(count1_q, sample_ev && snn_output_spikes[1]);
            under_q  <= sat_inc(under_q, underrun_ev);
            over_q   <= sat_inc(over_q, overrun_ev);
        end
    end

    assign spike_count    = {count1_q, count0_q};
    assign underrun_count = under_q;
    assign overrun_count  = over_q;
`else
    logic unused_spikes;

    assign unused_spikes  = ^snn_output_spikes;
    assign spike_count    = '0;
    assign underrun_count = '0;
    assign overrun_count  = '0;
`endif

endmodule

// File: tb/tb_snn_frame_scheduler.sv
// tb/tb_snn_frame_scheduler.sv - directed self-checking bench for snn_frame_scheduler
module tb_snn_frame_scheduler;

    localparam int DEPTH  = 4;
    localparam int SETTLE = 2;
`ifdef SNN_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        system_clock;
    logic        reset;
    logic        frame_valid;
    logic [7:0]  frame_data;
    logic        frame_ready;
    logic        tick;
    logic        run_en;
    logic        snn_enable;
    logic [7:0]  snn_input_spikes;
    logic [1:0]  snn_output_spikes;
    logic        busy;
    logic [4:0]  fifo_level;
    logic [15:0] spike_count;
    logic [7:0]  underrun_count;
    logic [7:0]  overrun_count;

    int errors = 0;
    int checks = 0;
    int en_pulses = 0;

    snn_frame_scheduler #(
        .DEPTH  (DEPTH),
        .SETTLE (SETTLE)
    ) dut (
        .system_clock      (system_clock),
        .reset             (reset),
        .frame_valid       (frame_valid),
        .frame_data        (frame_data),
        .frame_ready       (frame_ready),
        .tick              (tick),
        .run_en            (run_en),
        .snn_enable        (snn_enable),
        .snn_input_spikes  (snn_input_spikes),
        .snn_output_spikes (snn_output_spikes),
        .busy              (busy),
        .fifo_level        (fifo_level),
        .spike_count       (spike_count),
        .underrun_count    (underrun_count),
        .overrun_count     (overrun_count)
    );

    initial begin
        system_clock = 1'b0;
        forever #5 system_clock = ~system_clock;
    end

    always @(negedge system_clock) begin
        if (reset && snn_enable) en_pulses++;
    end

    function automatic logic [31:0] st(input logic [31:0] v);
        return STATS ? v : 32'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge system_clock);
        #1;
    endtask

    task automatic run_frame(input logic [7:0] exp);
        run_en = 1'b1;
        tick   = 1'b1;
        cyc(1);
        tick   = 1'b0;
        check("frame_enable", snn_enable, 1);
        check("frame_spikes", snn_input_spikes, exp);
        cyc(SETTLE + 2);
        check("frame_done_busy", busy, 0);
    endtask

    initial begin
        reset = 1'b0;
        frame_valid = 1'b0;
        frame_data = 8'h00;
        tick = 1'b0;
        run_en = 1'b0;
        snn_output_spikes = 2'b00;
        cyc(2);
        check("rst_ready", frame_ready, 1);
        check("rst_level", fifo_level, 0);
        check("rst_busy", busy, 0);
        check("rst_enable", snn_enable, 0);
        check("rst_spikes", snn_input_spikes, 0);
        check("rst_spike_count", spike_count, 0);
        reset = 1'b1;
        cyc(1);

        // Single frame 0xA5, outputs 01 at SAMPLE
        frame_valid = 1'b1;
        frame_data = 8'hA5;
        snn_output_spikes = 2'b01;
        cyc(1);
        frame_valid = 1'b0;
        check("a5_level_push", fifo_level, 1);
        run_en = 1'b1;
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        check("a5_enable", snn_enable, 1);
        check("a5_spikes", snn_input_spikes, 8'hA5);
        check("a5_busy_issue", busy, 1);
        check("a5_level_pop", fifo_level, 0);
        cyc(1);
        check("a5_enable_low", snn_enable, 0);
        check("a5_busy_w1", busy, 1);
        cyc(1);
        check("a5_busy_w2", busy, 1);
        cyc(1);
        check("a5_busy_sample", busy, 1);
        cyc(1);
        check("a5_busy_idle", busy, 0);
        check("a5_spikes_hold", snn_input_spikes, 8'hA5);
        check("a5_spike_count", spike_count, st(16'h0001));
        snn_output_spikes = 2'b00;

        // Fill to DEPTH with issue frozen, 5th frame refused
        run_en = 1'b0;
        frame_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            frame_data = 8'(8'h11 * (i + 1));
            cyc(1);
        end
        check("fill_level4", fifo_level, 4);
        check("fill_ready0", frame_ready, 0);
        frame_data = 8'h55;
        cyc(1);
        check("fill5_level", fifo_level, 4);
        check("fill5_ready", frame_ready, 0);
        frame_valid = 1'b0;

        // Tick with run_en=0 is ignored
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        check("runoff_busy", busy, 0);
        check("runoff_level", fifo_level, 4);
        check("runoff_under", underrun_count, 0);
        check("runoff_over", overrun_count, 0);

        // Issue 0x11 with a second tick during ISSUE
        run_en = 1'b1;
        tick = 1'b1;
        cyc(1);
        check("ov_enable", snn_enable, 1);
        check("ov_spikes", snn_input_spikes, 8'h11);
        check("ov_level", fifo_level, 3);
        check("ov_ready", frame_ready, 1);
        cyc(1);
        tick = 1'b0;
        check("ov_enable_low", snn_enable, 0);
        check("ov_busy", busy, 1);
        check("ov_count", overrun_count, st(1));
        cyc(SETTLE + 1);
        check("ov_idle", busy, 0);
        check("ov_level_after", fifo_level, 3);
        run_frame(8'h22);
        run_frame(8'h33);
        run_frame(8'h44);
        frame_valid = 1'b1;
        frame_data = 8'h55;
        cyc(1);
        frame_valid = 1'b0;
        run_frame(8'h55);
        check("drain_level", fifo_level, 0);
        check("pulses_6", en_pulses, 6);

        // Underrun, push invisible to same-cycle tick, simultaneous push/pop
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        check("ur_enable", snn_enable, 0);
        check("ur_busy", busy, 0);
        check("ur_count1", underrun_count, st(1));
        frame_valid = 1'b1;
        frame_data = 8'h66;
        tick = 1'b1;
        cyc(1);
        check("ur2_busy", busy, 0);
        check("ur2_level", fifo_level, 1);
        check("ur2_count", underrun_count, st(2));
        frame_data = 8'h77;
        cyc(1);
        frame_valid = 1'b0;
        tick = 1'b0;
        check("pp_enable", snn_enable, 1);
        check("pp_spikes", snn_input_spikes, 8'h66);
        check("pp_level", fifo_level, 1);
        cyc(SETTLE + 2);
        run_frame(8'h77);
        check("pulses_8", en_pulses, 8);

        // 300 frames with both outputs spiking -> saturation
        snn_output_spikes = 2'b11;
        for (int i = 0; i < 300; i++) begin
            frame_valid = 1'b1;
            frame_data = 8'(i);
            cyc(1);
            frame_valid = 1'b0;
            tick = 1'b1;
            cyc(1);
            tick = 1'b0;
            cyc(SETTLE + 2);
        end
        check("sat_spike_count", spike_count, st(16'hFFFF));
        check("sat_pulses", en_pulses, 308);
        check("sat_under", underrun_count, st(2));
        check("sat_over", overrun_count, st(1));
        check("sat_last_spikes", snn_input_spikes, 8'(299));
        snn_output_spikes = 2'b00;

        // Reset during SETTLE_WAIT
        frame_valid = 1'b1;
        frame_data = 8'h3C;
        cyc(1);
        frame_data = 8'h5A;
        cyc(1);
        frame_valid = 1'b0;
        check("mr_level2", fifo_level, 2);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        check("mr_spikes_3c", snn_input_spikes, 8'h3C);
        cyc(1);
        check("mr_busy_wait", busy, 1);
        #1 reset = 1'b0;
        #1;
        check("mr_busy", busy, 0);
        check("mr_enable", snn_enable, 0);
        check("mr_spikes", snn_input_spikes, 0);
        check("mr_level", fifo_level, 0);
        check("mr_ready", frame_ready, 1);
        check("mr_spike_count", spike_count, 0);
        check("mr_under", underrun_count, 0);
        check("mr_over", overrun_count, 0);
        @(posedge system_clock);
        #1 reset = 1'b1;
        frame_valid = 1'b1;
        frame_data = 8'h99;
        cyc(1);
        frame_valid = 1'b0;
        check("post_level", fifo_level, 1);
        run_frame(8'h99);
        check("post_level0", fifo_level, 0);
        check("post_spike_count", spike_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snn_frame_scheduler.md
SNN_FRAME_SCHEDULER -- requirements
Module: snn_frame_scheduler

Interface
REQ-001 Parameter DEPTH, default 4: input frame FIFO depth; power of two, 2..16.
REQ-002 Parameter SETTLE, default 2: cycles between the snn_enable pulse and output-spike sampling; 1..15.
REQ-003 system_clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 frame_valid  in  1  requester offers a frame.
REQ-006 frame_data  in  8  input spike frame, one bit per input neuron.
REQ-007 frame_ready  out  1  FIFO can accept a frame.
REQ-008 tick  in  1  one-cycle pulse, synchronous to system_clock, marking a delay_clk period.
REQ-009 run_en  in  1  scheduling enable; 0 freezes issue, but the FIFO still accepts frames.
REQ-010 snn_enable  out  1  one-cycle enable pulse to the SNN core.
REQ-011 snn_input_spikes  out  8  frame presented to the SNN core.
REQ-012 snn_output_spikes  in  2  output-layer spikes from the SNN core.
REQ-013 busy  out  1  FSM not in IDLE.
REQ-014 fifo_level  out  5  current FIFO occupancy.
REQ-015 spike_count  out  16  {count1[7:0], count0[7:0]}, saturating per-output spike counts.
REQ-016 underrun_count, overrun_count  out  8 each  saturating event counters.

Function
REQ-017 A push occurs when frame_valid && frame_ready; frame_ready = (fifo_level != DEPTH).
- frame_data is not sampled while the FIFO is full.
REQ-018 FSM states:
- IDLE -> ISSUE: tick && run_en && fifo_level != 0.
- ISSUE (1 cycle) -> SETTLE_WAIT.
- SETTLE_WAIT: lasts SETTLE cycles -> SAMPLE.
- SAMPLE (1 cycle) -> IDLE.
REQ-019 Entering ISSUE pops the FIFO head into snn_input_spikes; snn_enable is 1 exactly during the ISSUE cycle.
- snn_input_spikes holds its value until the next pop.
REQ-020 Latency: snn_enable rises on the clock edge after the qualifying tick.
- Sampling occurs SETTLE+1 cycles after the snn_enable pulse.
REQ-021 In SAMPLE, count0 += snn_output_spikes[0] and count1 += snn_output_spikes[1]; each counter saturates at 255.
REQ-022 tick in IDLE with run_en=1 and an empty FIFO: no issue; underrun_count increments.
REQ-023 tick while busy: tick is dropped; overrun_count increments; the FSM is unaffected.
REQ-024 tick with run_en=0: ignored; no counters change.
REQ-025 Simultaneous push and pop: both occur; fifo_level is unchanged.
- A push into an empty FIFO in the same cycle as a tick is not visible to that tick; it counts as underrun.
REQ-026 FIFO read and write pointers wrap modulo DEPTH; fifo_level never exceeds DEPTH.
REQ-027 run_en deasserted mid-frame: the current frame completes through SAMPLE.

Reset
REQ-028 Asserting reset at any time, including mid-frame, forces the following in the same instant:
- FSM to IDLE; FIFO empty; fifo_level=0; frame_ready=1.
- snn_enable=0; snn_input_spikes=0; busy=0.
- spike_count, underrun_count and overrun_count = 0.
REQ-029 After reset deasserts, the first tick is honoured no earlier than the following edge.

Configuration
REQ-030 Macro SNN_SCHED_STATS_EN:
- Defined: spike_count, underrun_count and overrun_count behave per REQ-021..023.
- Undefined: those counters are not built and the three outputs are constant 0; scheduling behaviour is identical.

Structure
REQ-031 A shared package snn_sched_pkg holds:
- the FSM state enumeration (IDLE, ISSUE, SETTLE_WAIT, SAMPLE);
- counter width constants (8) and the frame width constant (8).
REQ-032 The FIFO is a sub-module, snn_frame_fifo (parameter DEPTH, width 8), with push/pop/level ports; the scheduler FSM stays in the top.

Verification
REQ-033 Reset, push 0xA5, tick with run_en=1 -> snn_enable pulses one cycle later with snn_input_spikes=0xA5; busy=1 for SETTLE+2 cycles; fifo_level 1->0.
REQ-034 DEPTH=4: push 5 frames back-to-back -> frame_ready=0 after the 4th; the 5th is held by the requester; fifo_level=4.
REQ-035 Tick with the FIFO empty -> no snn_enable; underrun_count=1. A second tick during ISSUE of a real frame -> overrun_count=1 and no extra enable.
REQ-036 snn_output_spikes=2'b11 at SAMPLE for 300 frames -> count0=count1=255 (saturated).
REQ-037 Assert reset during SETTLE_WAIT -> all outputs at reset values immediately; the next frame issues normally.
REQ-038 Build without SNN_SCHED_STATS_EN and rerun REQ-033..036 -> identical snn_enable/snn_input_spikes trace; statistics outputs constant 0.
